// File: rtl/calc_sequencer.sv
// calc_sequencer: calculator control FSM that assembles A/op/B from grid selection
// codes, sequences a single-cycle ALU and a shift-add multiplier, and drives the display.
// Ports: clk, rst (async active-low), sel/val (select pulse + code), dec_mode,
//        restriction (= dec_mode), display, state, busy (in COMPUTE), done (SHOW entry pulse).
// Optional: define CALC_OVF_EN to add the ovf output (carry/borrow/product overflow).
module calc_sequencer #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [4:0]       val,
    input  logic             dec_mode,
    output logic             restriction,
    output logic [WIDTH-1:0] display,
    output logic [1:0]       state,
    output logic             busy,
`ifdef CALC_OVF_EN
    output logic             ovf,
`endif
    output logic             done
);
    typedef enum logic [1:0] {ENTER_A, ENTER_B, COMPUTE, SHOW} state_e;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int MW = $clog2(WIDTH);
`ifdef CALC_OVF_EN
    localparam int PW = 2 * WIDTH;
`else
    localparam int PW = WIDTH;
`endif
    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, disp_q;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [MW-1:0]    mcnt_q, mcnt_d;
    logic [PW-1:0]    prod_q, prod_d, prod_n;
    logic             done_q, done_d, wipe;
    logic [4:0]       base;
    logic [WIDTH-1:0] base_w, add_r, alu;
    logic             is_op, dig_base, dig_ok;
    assign restriction = dec_mode;
    assign state       = state_q;
    assign busy        = state_q == COMPUTE;
    assign done        = done_q;
    assign base        = dec_mode ? 5'd10 : 5'd16;
    assign base_w      = WIDTH'(base);
    assign dig_base    = val < base;
    assign dig_ok      = dig_base && cnt_q < CW'(DIGITS);
    assign is_op       = val inside {5'h10, 5'h11, 5'h12, 5'h14, 5'h15};
`ifdef CALC_OVF_EN
    logic carry, alu_ovf, ovf_q, ovf_d;
    assign {carry, add_r} = {1'b0, a_q} + {1'b0, b_q};
    assign alu_ovf = op_q == 3'd0 ? carry : op_q == 3'd4 ? a_q < b_q : 1'b0;
    assign ovf = ovf_q;
`else
    assign add_r = a_q + b_q;
`endif
    // op_q holds val[2:0]: 0 add, 1 mul, 2 and, 4 sub, 5 or
    assign alu = op_q == 3'd0 ? add_r : op_q == 3'd4 ? a_q - b_q : op_q == 3'd2 ? a_q & b_q : a_q | b_q;
    // One shift-add step per cycle; the accumulator restarts on the first step
    assign prod_n = (mcnt_q == '0 ? '0 : prod_q) + (b_q[mcnt_q] ? PW'(a_q) << mcnt_q : '0);
    // COMPUTE shows whatever was on screen when it was entered
    assign display = state_q == ENTER_A ? a_q :
                     state_q == ENTER_B ? (cnt_q != '0 ? b_q : a_q) :
                     state_q == SHOW ? res_q : disp_q;
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        mcnt_d  = mcnt_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
        wipe    = 1'b0;
`ifdef CALC_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            ENTER_A: if (sel) begin
                if (dig_ok) begin
                    a_d   = a_q * base_w + WIDTH'(val);
                    cnt_d = cnt_q + CW'(1);
                end else if (is_op) begin
                    op_d    = val[2:0];
                    b_d     = '0;
                    cnt_d   = '0;
                    state_d = ENTER_B;
                end else if (val == 5'h16) begin
                    a_d   = '0;
                    cnt_d = '0;
                end else if (val == 5'h17) begin
                    wipe = 1'b1;
                end
            end
            ENTER_B: if (sel) begin
                if (dig_ok) begin
                    b_d   = b_q * base_w + WIDTH'(val);
                    cnt_d = cnt_q + CW'(1);
                end else if (is_op) begin
                    op_d = val[2:0];
                end else if (val == 5'h16) begin
                    b_d   = '0;
                    cnt_d = '0;
`ifdef CALC_OVF_EN
                    ovf_d = 1'b0;
`endif
                end else if (val == 5'h17) begin
                    wipe    = 1'b1;
                    state_d = ENTER_A;
                end else if (val == 5'h13) begin
                    state_d = COMPUTE;
                end
            end
            COMPUTE: if (op_q == 3'd1) begin
                prod_d = prod_n;
                mcnt_d = mcnt_q + MW'(1);
                if (mcnt_q == MW'(WIDTH - 1)) begin
                    res_d   = prod_n[WIDTH-1:0];
                    mcnt_d  = '0;
                    done_d  = 1'b1;
                    state_d = SHOW;
`ifdef CALC_OVF_EN
                    ovf_d   = |prod_n[PW-1:WIDTH];
`endif
                end
            end else begin
                res_d   = alu;
                done_d  = 1'b1;
                state_d = SHOW;
`ifdef CALC_OVF_EN
                ovf_d   = alu_ovf;
`endif
            end
            SHOW: if (sel) begin
                if (dig_base) begin
                    a_d     = WIDTH'(val);
                    cnt_d   = CW'(1);
                    state_d = ENTER_A;
                end else if (is_op) begin
                    a_d     = res_q;
                    op_d    = val[2:0];
                    b_d     = '0;
                    cnt_d   = '0;
                    state_d = ENTER_B;
                end else if (val == 5'h13) begin
                    a_d     = res_q;
                    state_d = COMPUTE;
                end else if (val == 5'h16 || val == 5'h17) begin
                    wipe    = 1'b1;
                    state_d = ENTER_A;
                end
            end
            default: state_d = ENTER_A;
        endcase
        if (wipe) begin
            a_d   = '0;
            b_d   = '0;
            res_d = '0;
            op_d  = '0;
            cnt_d = '0;
        end
`ifdef CALC_OVF_EN
        if (state_d == ENTER_A) ovf_d = 1'b0;
`endif
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            mcnt_q  <= '0;
            prod_q  <= '0;
            done_q  <= 1'b0;
            disp_q  <= '0;
`ifdef CALC_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            mcnt_q  <= mcnt_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
            disp_q  <= display;
`ifdef CALC_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed self-checking bench for calc_sequencer
module tb_calc_sequencer;
    logic        clk = 1'b0;
    logic        rst, sel, dec_mode, restriction, busy, done;
    logic [4:0]  val;
    logic [15:0] display;
    logic [1:0]  state;
`ifdef CALC_OVF_EN
    logic        ovf;
`endif
    int errors = 0;
    int checks = 0;

    calc_sequencer dut (
        .clk(clk), .rst(rst), .sel(sel), .val(val), .dec_mode(dec_mode),
        .restriction(restriction), .display(display), .state(state), .busy(busy),
`ifdef CALC_OVF_EN
        .ovf(ovf),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic press(input logic [4:0] v);
        @(negedge clk);
        sel = 1'b1;
        val = v;
        @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic run_exe();
        press(5'h13);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        checks++; if (display !== 16'h0000) begin errors++; $display("FAIL reset_display got=%h exp=0000", display); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_add();
        press(5'h1); press(5'h2);
        checks++; if (display !== 16'h0012) begin errors++; $display("FAIL add_a got=%h exp=0012", display); end
        press(5'h10);
        checks++; if (display !== 16'h0012 || state !== 2'd1) begin errors++; $display("FAIL add_op got=%h/%0d exp=0012/1", display, state); end
        press(5'h3);
        checks++; if (display !== 16'h0003) begin errors++; $display("FAIL add_b got=%h exp=0003", display); end
        press(5'h13);
        checks++; if (busy !== 1'b1 || state !== 2'd2 || done !== 1'b0) begin errors++; $display("FAIL add_compute got=%b%0d%b exp=1 2 0", busy, state, done); end
        @(negedge clk);
        checks++; if (state !== 2'd3 || display !== 16'h0015 || done !== 1'b1) begin errors++; $display("FAIL add_show got=%0d/%h/%b exp=3/0015/1", state, display, done); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_pulse got=%b exp=0", done); end
        press(5'h17);
    endtask

    task automatic test_mul();
        int n = 0;
        bit early = 0;
        press(5'h1); press(5'h2); press(5'h11); press(5'h3); press(5'h4);
        press(5'h13);
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
            n++;
            if (done === 1'b1) early = 1;
            sel = 1'b1;
            val = 5'h07;
            @(negedge clk);
        end
        sel = 1'b0;
        checks++; if (n !== 16) begin errors++; $display("FAIL mul_busy_cycles got=%0d exp=16", n); end
        checks++; if (early) begin errors++; $display("FAIL mul_done_early got=1 exp=0"); end
        checks++; if (display !== 16'h03A8 || state !== 2'd3 || done !== 1'b1) begin errors++; $display("FAIL mul_result got=%h/%0d/%b exp=03a8/3/1", display, state, done); end
        press(5'h17);
    endtask

    task automatic test_sub();
        press(5'h1); press(5'h14); press(5'h2);
        run_exe();
        checks++; if (display !== 16'hFFFF) begin errors++; $display("FAIL sub_result got=%h exp=ffff", display); end
`ifdef CALC_OVF_EN
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sub_ovf got=%b exp=1", ovf); end
`endif
        run_exe();
        checks++; if (display !== 16'hFFFD) begin errors++; $display("FAIL sub_repeat got=%h exp=fffd", display); end
`ifdef CALC_OVF_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sub_repeat_ovf got=%b exp=0", ovf); end
`endif
        press(5'h17);
    endtask

    task automatic test_dec();
        dec_mode = 1'b1;
        #1;
        checks++; if (restriction !== 1'b1) begin errors++; $display("FAIL dec_restriction got=%b exp=1", restriction); end
        press(5'h1); press(5'h2); press(5'hA);
        checks++; if (display !== 16'h000C) begin errors++; $display("FAIL dec_a got=%h exp=000c", display); end
        press(5'h10); press(5'h5);
        run_exe();
        checks++; if (display !== 16'h0011) begin errors++; $display("FAIL dec_result got=%h exp=0011", display); end
        dec_mode = 1'b0;
        #1;
        checks++; if (restriction !== 1'b0) begin errors++; $display("FAIL hex_restriction got=%b exp=0", restriction); end
        press(5'h17);
    endtask

    task automatic test_limit_chain();
        press(5'h1); press(5'h2); press(5'h3); press(5'h4); press(5'h5);
        checks++; if (display !== 16'h1234) begin errors++; $display("FAIL limit got=%h exp=1234", display); end
        press(5'h1F);
        checks++; if (display !== 16'h1234 || state !== 2'd0) begin errors++; $display("FAIL invalid_code got=%h/%0d exp=1234/0", display, state); end
        press(5'h16);
        checks++; if (display !== 16'h0000) begin errors++; $display("FAIL ce got=%h exp=0000", display); end
        press(5'h7); press(5'h15); press(5'h8);
        run_exe();
        checks++; if (display !== 16'h000F) begin errors++; $display("FAIL or_result got=%h exp=000f", display); end
        press(5'h12);
        checks++; if (display !== 16'h000F || state !== 2'd1) begin errors++; $display("FAIL chain_op got=%h/%0d exp=000f/1", display, state); end
        press(5'hC);
        run_exe();
        checks++; if (display !== 16'h000C) begin errors++; $display("FAIL and_result got=%h exp=000c", display); end
        press(5'h9);
        checks++; if (display !== 16'h0009 || state !== 2'd0) begin errors++; $display("FAIL show_digit got=%h/%0d exp=0009/0", display, state); end
        press(5'h17);
    endtask

    task automatic test_reset_mid_mul();
        bit seen = 0;
        press(5'h1); press(5'h2); press(5'h11); press(5'h3); press(5'h4);
        press(5'h13);
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_mul_busy got=%b exp=1", busy); end
        #2 rst = 1'b0;
        #1;
        checks++; if (display !== 16'h0000 || state !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mid_mul_reset got=%h/%0d/%b/%b exp=0000/0/0/0", display, state, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1 || state !== 2'd0) seen = 1;
        end
        checks++; if (seen) begin errors++; $display("FAIL mid_mul_after got=done_or_state exp=idle"); end
    endtask

    initial begin
        sel = 1'b0;
        val = 5'h00;
        dec_mode = 1'b0;
        test_reset();
        test_add();
        test_mul();
        test_sub();
        test_dec();
        test_limit_chain();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
